// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator and detector: state codes and
// the filler LFSR (x^7 + x^6 + 1) constants.
package seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SEND = 2'b01;
  localparam logic [1:0] ST_GAP  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam logic [6:0] LFSR_SEED = 7'h01;
  localparam logic [6:0] LFSR_TAPS = 7'b110_0000;

  // Fibonacci step: output is bit 6, feedback enters at bit 0.
  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/seq_bit_tick.sv
// Bit-period divider: `tick` marks the last clock of every BIT_DIV-clock bit,
// `tick_pre` says that the next clock will carry a tick.
module seq_bit_tick #(
  parameter int BIT_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic tick_pre
);

  generate
    if (BIT_DIV == 1) begin : g_bypass
      logic unused_in;
      assign unused_in = clk ^ rst ^ clr;
      assign tick      = 1'b1;
      assign tick_pre  = 1'b1;
    end else begin : g_div
      localparam int CW = $clog2(BIT_DIV);
      logic [CW-1:0] cnt_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          cnt_reg <= '0;
        else if (clr || cnt_reg == CW'(BIT_DIV - 1))
          cnt_reg <= '0;
        else
          cnt_reg <= cnt_reg + 1'b1;
      end

      assign tick     = (cnt_reg == CW'(BIT_DIV - 1));
      assign tick_pre = !clr && (cnt_reg == CW'(BIT_DIV - 2));
    end
  endgenerate

endmodule

// File: rtl/seq_gen.sv
// Serial pattern transmitter feeding the sequence detector. Define
// SEQ_GEN_PRBS_EN to fill inter-frame gaps with LFSR bits instead of IDLE_LVL.
import seq_pkg::*;

module seq_gen #(
  parameter int   PATTERN_W = 4,
  parameter int   CNT_W     = 4,
  parameter int   GAP_W     = 4,
  parameter int   BIT_DIV   = 1,
  parameter logic IDLE_LVL  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [CNT_W-1:0]     repeat_n,
  input  logic [GAP_W-1:0]     gap_n,
  output logic                 signal,
  output logic                 frame_done,
  output logic                 done,
  output logic [1:0]           outlet,
  output logic                 led
);

  localparam int BC_W = $clog2(PATTERN_W);
  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(PATTERN_W - 1);

  logic [1:0]           state_reg, state_next;
  logic [PATTERN_W-1:0] pat_reg, pat_next, shift_reg, shift_next;
  logic [BC_W-1:0]      bit_cnt_reg, bit_cnt_next;
  logic [CNT_W-1:0]     frame_cnt_reg, frame_cnt_next;
  logic [GAP_W-1:0]     gap_lat_reg, gap_lat_next, gap_cnt_reg, gap_cnt_next;
  logic signal_reg, signal_next, frame_done_reg, frame_done_next;
  logic done_reg, done_next, led_reg, led_next;
  logic tick, tick_pre, clr, gap_bit;

  assign clr = (state_reg == ST_IDLE) || (state_reg == ST_DONE);

  seq_bit_tick #(.BIT_DIV(BIT_DIV)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .tick     (tick),
    .tick_pre (tick_pre)
  );

`ifdef SEQ_GEN_PRBS_EN
  logic [6:0] lfsr_reg, lfsr_next;
  assign lfsr_next = (state_reg == ST_GAP && tick) ? lfsr_step(lfsr_reg) : lfsr_reg;
  assign gap_bit   = lfsr_next[6];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_reg <= LFSR_SEED;
    else      lfsr_reg <= lfsr_next;
  end
`else
  assign gap_bit = IDLE_LVL;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      pat_reg        <= '0;
      shift_reg      <= '0;
      bit_cnt_reg    <= '0;
      frame_cnt_reg  <= '0;
      gap_lat_reg    <= '0;
      gap_cnt_reg    <= '0;
      signal_reg     <= IDLE_LVL;
      frame_done_reg <= 1'b0;
      done_reg       <= 1'b0;
      led_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      pat_reg        <= pat_next;
      shift_reg      <= shift_next;
      bit_cnt_reg    <= bit_cnt_next;
      frame_cnt_reg  <= frame_cnt_next;
      gap_lat_reg    <= gap_lat_next;
      gap_cnt_reg    <= gap_cnt_next;
      signal_reg     <= signal_next;
      frame_done_reg <= frame_done_next;
      done_reg       <= done_next;
      led_reg        <= led_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    pat_next       = pat_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    frame_cnt_next = frame_cnt_reg;
    gap_lat_next   = gap_lat_reg;
    gap_cnt_next   = gap_cnt_reg;
    case (state_reg)
      ST_IDLE: if (start) begin
        state_next     = ST_SEND;
        pat_next       = pattern;
        shift_next     = pattern;
        bit_cnt_next   = BIT_LAST;
        frame_cnt_next = repeat_n;
        gap_lat_next   = gap_n;
      end
      ST_SEND: if (tick) begin
        if (bit_cnt_reg != '0) begin
          shift_next   = shift_reg << 1;
          bit_cnt_next = bit_cnt_reg - 1'b1;
        end else if (frame_cnt_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          frame_cnt_next = frame_cnt_reg - 1'b1;
          if (gap_lat_reg != '0) begin
            state_next   = ST_GAP;
            gap_cnt_next = gap_lat_reg - 1'b1;
          end else begin
            shift_next   = pat_reg;
            bit_cnt_next = BIT_LAST;
          end
        end
      end
      ST_GAP: if (tick) begin
        if (gap_cnt_reg != '0) begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
        end else begin
          state_next   = ST_SEND;
          shift_next   = pat_reg;
          bit_cnt_next = BIT_LAST;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values so they can be registered
  // without adding a cycle of latency.
  always_comb begin
    case (state_next)
      ST_SEND: signal_next = shift_next[PATTERN_W-1];
      ST_GAP:  signal_next = gap_bit;
      default: signal_next = IDLE_LVL;
    endcase
    frame_done_next = (state_next == ST_SEND) && (bit_cnt_next == '0) && tick_pre;
    done_next       = (state_next == ST_DONE);
    led_next        = (state_next == ST_SEND) || (state_next == ST_GAP);
  end

  assign signal     = signal_reg;
  assign frame_done = frame_done_reg;
  assign done       = done_reg;
  assign outlet     = state_reg;
  assign led        = led_reg;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: two instances (BIT_DIV=1 and BIT_DIV=2),
// per-cycle expected outputs queued at start and compared as the DUT runs.
module tb_seq_gen;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start1 = 1'b0, start2 = 1'b0;
  logic [3:0] pattern = '0, repeat_n = '0, gap_n = '0;
  logic       sig1, fd1, done1, led1, sig2, fd2, done2, led2;
  logic [1:0] out1, out2;
  int         total = 0;
  int         bad = 0;
  logic [6:0] lfsr_m [2];

  always #5 clk = ~clk;

  seq_gen #(.PATTERN_W(4), .CNT_W(4), .GAP_W(4), .BIT_DIV(1), .IDLE_LVL(1'b0)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pattern(pattern), .repeat_n(repeat_n),
    .gap_n(gap_n), .signal(sig1), .frame_done(fd1), .done(done1), .outlet(out1), .led(led1)
  );

  seq_gen #(.PATTERN_W(4), .CNT_W(4), .GAP_W(4), .BIT_DIV(2), .IDLE_LVL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .pattern(pattern), .repeat_n(repeat_n),
    .gap_n(gap_n), .signal(sig2), .frame_done(fd2), .done(done2), .outlet(out2), .led(led2)
  );

  // {signal, frame_done, done, outlet[1:0], led}
  function automatic logic [5:0] obs(input int sel);
    return (sel == 0) ? {sig1, fd1, done1, out1, led1} : {sig2, fd2, done2, out2, led2};
  endfunction

  function automatic logic [6:0] model_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    total++;
    assert (got == want) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic run_txn(input int sel, input logic [3:0] pat, input logic [3:0] rep,
                         input logic [3:0] gap, input int poke_at, input int abort_at,
                         input string tag, output int fd_n, output int done_n, output int led_n);
    logic [5:0] exp_q[$];
    logic [5:0] e, o;
    int bd;
    int idx;
    bd = (sel == 0) ? 1 : 2;
    idx = 0;
    fd_n = 0; done_n = 0; led_n = 0;
    for (int f = 0; f <= int'(rep); f++) begin
      for (int b = 3; b >= 0; b--)
        for (int t = 0; t < bd; t++)
          exp_q.push_back({pat[b], (b == 0 && t == bd - 1), 1'b0, 2'b01, 1'b1});
      if (f < int'(rep)) begin
        for (int g = 0; g < int'(gap); g++) begin
          logic gb;
`ifdef SEQ_GEN_PRBS_EN
          gb = lfsr_m[sel][6];
          lfsr_m[sel] = model_step(lfsr_m[sel]);
`else
          gb = 1'b0;
`endif
          for (int t = 0; t < bd; t++)
            exp_q.push_back({gb, 1'b0, 1'b0, 2'b10, 1'b1});
        end
      end
    end
    exp_q.push_back({1'b0, 1'b0, 1'b1, 2'b11, 1'b0});
    exp_q.push_back(6'b000000);

    @(negedge clk);
    pattern = pat; repeat_n = rep; gap_n = gap;
    if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      start1 = 1'b0; start2 = 1'b0;
      if (idx == abort_at) begin
        rst = 1'b0;
        #1;
        check($sformatf("%s/abort", tag), obs(sel), 6'b000000);
        lfsr_m[0] = 7'h01; lfsr_m[1] = 7'h01;
        @(negedge clk);
        check($sformatf("%s/abort_hold", tag), obs(sel), 6'b000000);
        rst = 1'b1;
        @(negedge clk);
        check($sformatf("%s/abort_idle", tag), obs(sel), 6'b000000);
        exp_q.delete();
        break;
      end
      e = exp_q.pop_front();
      o = obs(sel);
      check($sformatf("%s[%0d]", tag, idx), o, e);
      fd_n += int'(o[4]); done_n += int'(o[3]); led_n += int'(o[0]);
      if (idx == poke_at) begin
        pattern = ~pat; repeat_n = ~rep; gap_n = 4'd5;
        if (sel == 0) start1 = 1'b1; else start2 = 1'b1;
      end
      idx++;
    end
    $display("txn %s dut=%0d pat=%b rep=%0d gap=%0d cycles=%0d fd=%0d done=%0d led=%0d",
             tag, sel, pat, rep, gap, idx, fd_n, done_n, led_n);
  endtask

  initial begin
    int fd_n, done_n, led_n;
    lfsr_m[0] = 7'h01; lfsr_m[1] = 7'h01;

    // Reset held with start asserted, then idle with no start.
    rst = 1'b0; start1 = 1'b1; start2 = 1'b1; pattern = 4'hF;
    repeat (2) begin
      @(negedge clk);
      check("reset_d1", obs(0), 6'b000000);
      check("reset_d2", obs(1), 6'b000000);
    end
    rst = 1'b1; start1 = 1'b0; start2 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_d1", obs(0), 6'b000000);
      check("idle_d2", obs(1), 6'b000000);
    end
    $display("txn reset checked");

    run_txn(0, 4'b1011, 4'd0, 4'd0, -1, -1, "single", fd_n, done_n, led_n);
    check_int("single_fd", fd_n, 1);
    check_int("single_done", done_n, 1);
    check_int("single_led", led_n, 4);

    run_txn(1, 4'b1101, 4'd2, 4'd3, -1, -1, "gap", fd_n, done_n, led_n);
    check_int("gap_fd", fd_n, 3);
    check_int("gap_done", done_n, 1);
    check_int("gap_led", led_n, 36);

    run_txn(0, 4'b1001, 4'd1, 4'd0, -1, -1, "b2b", fd_n, done_n, led_n);
    check_int("b2b_fd", fd_n, 2);
    check_int("b2b_led", led_n, 8);

    run_txn(0, 4'b1010, 4'd15, 4'd0, -1, -1, "maxrep", fd_n, done_n, led_n);
    check_int("maxrep_fd", fd_n, 16);
    check_int("maxrep_led", led_n, 64);

    run_txn(1, 4'b1100, 4'd2, 4'd0, 3, 10, "abort", fd_n, done_n, led_n);
    check_int("abort_fd", fd_n, 1);
    check_int("abort_done", done_n, 0);

    run_txn(1, 4'b0110, 4'd1, 4'd7, -1, -1, "gap7", fd_n, done_n, led_n);
    check_int("gap7_fd", fd_n, 2);
    check_int("gap7_led", led_n, 30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
Name: seq_gen

Overview:
- Serial pattern transmitter that produces the `signal` stream consumed by the sequence detector.
- Accepts a parallel pattern, repeat count and inter-frame gap. Shifts the pattern out MSB-first on one wire at a programmable bit rate.
- Sits in front of the detector in system builds and benches, replacing hand-timed stimulus. Shows its FSM state on `outlet` and its busy status on `led`, matching the detector's board-level indicators.

Parameters:
- PATTERN_W, 4, pattern length in bits (>=2).
- CNT_W, 4, width of `repeat_n`.
- GAP_W, 4, width of `gap_n`.
- BIT_DIV, 1, clock cycles per transmitted bit (>=1).
- IDLE_LVL, 1'b0, level driven on `signal` when not sending pattern bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; accepted only in IDLE.
- pattern  in  PATTERN_W  pattern to send; sampled when `start` is accepted.
- repeat_n  in  CNT_W  frames to send = repeat_n+1; sampled with `start`.
- gap_n  in  GAP_W  IDLE_LVL bits between frames; sampled with `start`.
- signal  out  1  serial output, registered.
- frame_done  out  1  one-cycle pulse on the last clock of each frame's final bit.
- done  out  1  one-cycle pulse in DONE state.
- outlet  out  2  current state: IDLE=00, SEND=01, GAP=10, DONE=11.
- led  out  1  busy indicator; high in SEND or GAP.

Behaviour:
- Reset (rst=0, async): state IDLE, signal=IDLE_LVL, outlet=00, led=0, frame_done=0, done=0. All counters and the shift register clear.
- IDLE:
  - On `start`=1 at a clock edge: latch pattern, repeat_n and gap_n; load bit counter=PATTERN_W-1 and tick counter=0.
  - Next state SEND. `signal` is pattern[PATTERN_W-1] from the cycle after start (latency 1).
- Bit timing: each bit is held exactly BIT_DIV clocks. With BIT_DIV=1 the tick counter is bypassed and a new bit is sent every clock.
- SEND:
  - Shift out MSB-first.
  - After bit 0 has been held BIT_DIV clocks, assert `frame_done` for one cycle. This is the last cycle of bit 0.
  - Then:
    - If frames remain and latched gap_n>0 -> GAP.
    - If frames remain and gap_n=0 -> reload the shift register from the latched pattern and stay in SEND, back-to-back with no idle bit.
    - If no frames remain -> DONE.
- GAP: `signal`=IDLE_LVL for gap_n*BIT_DIV clocks, then reload the pattern and return to SEND.
- DONE:
  - One cycle; `done`=1, `signal`=IDLE_LVL, led=0.
  - Next state IDLE.
  - `start` in DONE is ignored.
- `start` while in SEND, GAP or DONE is ignored. Latched values are not disturbed by input changes during a transfer.
- Frame counter counts down from the latched repeat_n. repeat_n=all-ones sends 2^CNT_W frames without overflow.
- Reset asserted mid-frame aborts immediately. `signal` returns to IDLE_LVL asynchronously and no `done` pulse is produced.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SEQ_GEN_PRBS_EN.
- With it defined:
  - During GAP, `signal` is driven from a 7-bit Fibonacci LFSR (x^7+x^6+1), seed 7'h01 at reset. The LFSR advances once per bit period.
  - This inserts pseudo-random filler between frames to exercise detector false-match rejection.
- Without it: GAP drives IDLE_LVL and no LFSR logic is synthesized.
- All other timing is identical in both builds.

Decomposition:
- Package seq_pkg: state localparams (ST_IDLE=2'b00, ST_SEND=2'b01, ST_GAP=2'b10, ST_DONE=2'b11) and the LFSR seed/tap constants. The detector shares this package.
- Sub-module seq_bit_tick: bit-period divider with BIT_DIV parameter. Inputs clk, rst, clr; output one-cycle `tick` every BIT_DIV clocks, constant 1 when BIT_DIV=1.

Test Plan:
- Reset: hold rst=0 for 2 clocks with start=1 -> signal=0, outlet=00, led=0, no done. After release with no start, the FSM stays in IDLE.
- Single frame, BIT_DIV=1: pattern=4'b1011, repeat_n=0, gap_n=0, start pulse -> signal 1,0,1,1 on the 4 clocks after start; frame_done on the 4th; done on the 5th; outlet 01 for 4 clocks, then 11, then 00.
- Repeats with gap, BIT_DIV=2: pattern=4'b1101, repeat_n=2, gap_n=3 -> three frames, each bit held 2 clocks, separated by 6 low clocks. Exactly 3 frame_done pulses and 1 done; led high for 3*8+2*6=36 clocks.
- Back-to-back: pattern=4'b1001, repeat_n=1, gap_n=0 -> continuous 10011001 with no idle bit; outlet never shows 10.
- Ignored start and abort: re-pulse start mid-frame with a different pattern -> output unchanged. Then assert rst during frame 2 -> signal=0 immediately, outlet=00, no done pulse.
- SEQ_GEN_PRBS_EN build, gap_n=7: GAP bits equal the first 7 LFSR outputs from seed 7'h01. The SEND bits match the non-PRBS build.
